// File: rtl/rowbuffer_pingpong_ctrl_pkg.sv
// rowbuffer_pingpong_ctrl shared types and constants.
// Bank states, bank ids and read-path timing.
package rowbuffer_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    localparam int SKID_DEPTH = 4;
    localparam int RD_LAT     = 2;

endpackage

// File: rtl/rowbuffer_pingpong_ctrl_if.sv
// Producer/consumer row handshakes of the ping-pong row buffer.
// master = producer/consumer side, slave = controller side.
interface rowbuffer_pingpong_ctrl_if #(
    parameter int DW = 4096
);
    logic          fill_valid;
    logic          fill_ready;
    logic          fill_last;
    logic [DW-1:0] fill_data;
    logic          drain_valid;
    logic          drain_ready;
    logic          drain_last;
    logic [DW-1:0] drain_data;

    modport master (
        output fill_valid, fill_last, fill_data, drain_ready,
        input  fill_ready, drain_valid, drain_last, drain_data
    );

    modport slave (
        input  fill_valid, fill_last, fill_data, drain_ready,
        output fill_ready, drain_valid, drain_last, drain_data
    );
endinterface

// File: rtl/rowbuffer_pingpong_ctrl_skid_fifo.sv
// First-word-fall-through skid FIFO with occupancy count.
// Output data reads as zero while empty.
module rowbuffer_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & (r_count != CW'(DEPTH));
    assign w_pop   = i_pop & (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = o_valid ? r_mem[r_rp] : '0;
    assign o_count = r_count;

    // storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_pop)  r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end
endmodule

// File: rtl/rowbuffer_pingpong_ctrl.sv
// Ping-pong controller for a two-bank row buffer.
// One bank fills while the other drains through a credit-gated skid FIFO.
module rowbuffer_pingpong_ctrl
    import rowbuffer_pkg::*;
#(
    parameter int dataWidth = 32,
    parameter int pvadd     = 128,
    parameter int k         = 1024,
    localparam int addressWidth  = $clog2(k),
    localparam int dataportWidth = dataWidth * pvadd
) (
    input  logic                     clk,
    input  logic                     rst,
    rowbuffer_pingpong_ctrl_if.slave bus,
    output logic [1:0]               bank_full,
    output logic                     enableA,
    output logic                     enableB,
    output logic                     writeEnableA1,
    output logic                     writeEnableB1,
    output logic                     writeEnableA2,
    output logic                     writeEnableB2,
    output logic [addressWidth-1:0]  addressportA1,
    output logic [addressWidth-1:0]  addressportB1,
    output logic [addressWidth-1:0]  addressportA2,
    output logic [addressWidth-1:0]  addressportB2,
    output logic [dataportWidth-1:0] writeportA1,
    output logic [dataportWidth-1:0] writeportB1,
    output logic [dataportWidth-1:0] writeportA2,
    output logic [dataportWidth-1:0] writeportB2,
    input  logic [dataportWidth-1:0] readportA2,
    input  logic [dataportWidth-1:0] readportB2
);
    localparam int AW   = addressWidth;
    localparam int LW   = addressWidth + 1;
    localparam int CNTW = $clog2(SKID_DEPTH + 1);

    bank_state_t       r_state [2];
    logic [LW-1:0]     r_len   [2];
    logic              r_fill_sel;
    logic              r_drain_sel;
    logic [AW-1:0]     r_wr_ptr;
    logic [LW-1:0]     r_rd_ptr;
    logic [RD_LAT-1:0] r_rd_vld;
    logic [RD_LAT-1:0] r_rd_last;
    logic [RD_LAT-1:0] r_rd_bank;

    bank_state_t        w_drain_st;
    logic               w_fill_ready;
    logic               w_fill_fire;
    logic               w_fill_end;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_credit;
    logic               w_rd_done;
    logic [3:0]         w_used;
    logic               w_wr_a;
    logic               w_wr_b;
    logic               w_rd_a;
    logic               w_rd_b;
    logic               w_pop;
    logic               w_fifo_valid;
    logic [dataportWidth:0]   w_fifo_data;
    logic [CNTW-1:0]          w_fifo_count;
    logic [dataportWidth-1:0] w_rd_data;

    assign w_drain_st   = r_state[r_drain_sel];
    assign w_fill_ready = (r_state[r_fill_sel] == ST_EMPTY) ||
                          (r_state[r_fill_sel] == ST_FILLING);
    assign w_fill_fire  = bus.fill_valid & w_fill_ready & ~rst;
    assign w_fill_end   = w_fill_fire &
                          (bus.fill_last | (r_wr_ptr == AW'(k - 1)));

    // reads in flight plus rows already buffered bound the next issue
    always_comb begin
        w_used = 4'(w_fifo_count);
        for (int i = 0; i < RD_LAT; i++) w_used = w_used + 4'(r_rd_vld[i]);
    end

    assign w_credit     = w_used < 4'(SKID_DEPTH);
    assign w_issue      = ~rst & w_credit &
                          ((w_drain_st == ST_FULL) || (w_drain_st == ST_DRAINING)) &
                          (r_rd_ptr < r_len[r_drain_sel]);
    assign w_issue_last = w_issue & ((r_rd_ptr + LW'(1)) == r_len[r_drain_sel]);
    assign w_rd_done    = r_rd_vld[RD_LAT-2] & r_rd_last[RD_LAT-2];

    assign w_wr_a = w_fill_fire & (r_fill_sel == BANK_A);
    assign w_wr_b = w_fill_fire & (r_fill_sel == BANK_B);
    assign w_rd_a = w_issue & (r_drain_sel == BANK_A);
    assign w_rd_b = w_issue & (r_drain_sel == BANK_B);

    assign enableA       = w_wr_a | w_rd_a;
    assign enableB       = w_wr_b | w_rd_b;
    assign writeEnableA1 = w_wr_a;
    assign writeEnableB1 = w_wr_b;
    assign writeEnableA2 = 1'b0;
    assign writeEnableB2 = 1'b0;
    assign addressportA1 = w_wr_a ? r_wr_ptr : '0;
    assign addressportB1 = w_wr_b ? r_wr_ptr : '0;
    assign addressportA2 = w_rd_a ? r_rd_ptr[AW-1:0] : '0;
    assign addressportB2 = w_rd_b ? r_rd_ptr[AW-1:0] : '0;
    assign writeportA1   = bus.fill_data;
    assign writeportB1   = bus.fill_data;
    assign writeportA2   = '0;
    assign writeportB2   = '0;

    assign bank_full[0] = (r_state[0] == ST_FULL) || (r_state[0] == ST_DRAINING);
    assign bank_full[1] = (r_state[1] == ST_FULL) || (r_state[1] == ST_DRAINING);

    assign w_rd_data = r_rd_bank[RD_LAT-1] ? readportB2 : readportA2;
    assign w_pop     = w_fifo_valid & bus.drain_ready;

    assign bus.fill_ready  = w_fill_ready;
    assign bus.drain_valid = w_fifo_valid;
    assign bus.drain_last  = w_fifo_data[dataportWidth];
    assign bus.drain_data  = w_fifo_data[dataportWidth-1:0];

    // per-bank FSM, fill/drain pointers and bank selectors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0]  <= ST_EMPTY;
            r_state[1]  <= ST_EMPTY;
            r_len[0]    <= '0;
            r_len[1]    <= '0;
            r_fill_sel  <= BANK_A;
            r_drain_sel <= BANK_A;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_fill_end) begin
                r_state[r_fill_sel] <= ST_FULL;
                r_len[r_fill_sel]   <= LW'(r_wr_ptr) + LW'(1);
                r_wr_ptr            <= '0;
                r_fill_sel          <= ~r_fill_sel;
            end else if (w_fill_fire) begin
                r_state[r_fill_sel] <= ST_FILLING;
                r_wr_ptr            <= r_wr_ptr + AW'(1);
            end
            if (w_drain_st == ST_FULL) r_state[r_drain_sel] <= ST_DRAINING;
            if (w_issue) r_rd_ptr <= r_rd_ptr + LW'(1);
            if (w_rd_done) begin
                r_state[r_rd_bank[RD_LAT-2]] <= ST_EMPTY;
                r_rd_ptr                     <= '0;
                r_drain_sel                  <= ~r_drain_sel;
            end
        end
    end

    // read-latency tag pipeline; reset drops reads in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_vld  <= '0;
            r_rd_last <= '0;
            r_rd_bank <= '0;
        end else begin
            r_rd_vld  <= {r_rd_vld[RD_LAT-2:0], w_issue};
            r_rd_last <= {r_rd_last[RD_LAT-2:0], w_issue_last};
            r_rd_bank <= {r_rd_bank[RD_LAT-2:0], r_drain_sel};
        end
    end

    rowbuffer_skid_fifo #(
        .WIDTH(dataportWidth + 1),
        .DEPTH(SKID_DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_rd_vld[RD_LAT-1]),
        .i_data  ({r_rd_last[RD_LAT-1], w_rd_data}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );
endmodule

// File: tb/tb_rowbuffer_pingpong_ctrl.sv
// Directed bench for rowbuffer_pingpong_ctrl with a 2-cycle bank model.
// Small geometry: 16 rows per bank, 32-bit rows.
module tb_rowbuffer_pingpong_ctrl;
    localparam int DWD = 8;
    localparam int PV  = 4;
    localparam int K   = 16;
    localparam int AW  = 4;
    localparam int DPW = 32;
    localparam int LIM = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rowbuffer_pingpong_ctrl_if #(.DW(DPW)) bus();

    logic [1:0]     bank_full;
    logic           enableA, enableB;
    logic           writeEnableA1, writeEnableB1;
    logic           writeEnableA2, writeEnableB2;
    logic [AW-1:0]  addressportA1, addressportB1;
    logic [AW-1:0]  addressportA2, addressportB2;
    logic [DPW-1:0] writeportA1, writeportB1;
    logic [DPW-1:0] writeportA2, writeportB2;
    logic [DPW-1:0] memA [K];
    logic [DPW-1:0] memB [K];
    logic [DPW-1:0] pA1, pA2, pB1, pB2;

    rowbuffer_pingpong_ctrl #(
        .dataWidth(DWD), .pvadd(PV), .k(K)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .bank_full     (bank_full),
        .enableA       (enableA),
        .enableB       (enableB),
        .writeEnableA1 (writeEnableA1),
        .writeEnableB1 (writeEnableB1),
        .writeEnableA2 (writeEnableA2),
        .writeEnableB2 (writeEnableB2),
        .addressportA1 (addressportA1),
        .addressportB1 (addressportB1),
        .addressportA2 (addressportA2),
        .addressportB2 (addressportB2),
        .writeportA1   (writeportA1),
        .writeportB1   (writeportB1),
        .writeportA2   (writeportA2),
        .writeportB2   (writeportB2),
        .readportA2    (pA2),
        .readportB2    (pB2)
    );

    // bank model: write on port 1, 2-cycle registered read on port 2
    always @(posedge clk) begin
        if (enableA && writeEnableA1) memA[addressportA1] <= writeportA1;
        if (enableB && writeEnableB1) memB[addressportB1] <= writeportB1;
        pA1 <= memA[addressportA2];
        pA2 <= pA1;
        pB1 <= memB[addressportB2];
        pB2 <= pB1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [32:0] out_q [$];
    int          out_cyc [$];
    bit          bank_seq [$];
    int nrdA, nrdB, full_cyc_a, dv_rise, first_rd_a, last_rd_a, fr_rise;
    logic [1:0] bf_prev = 2'b00;
    logic       dv_prev = 1'b0;
    logic       fr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // observe handshakes, bank transitions and read issues away from the edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.drain_valid && bus.drain_ready) begin
                out_q.push_back({bus.drain_last, bus.drain_data});
                out_cyc.push_back(cyc);
            end
            if (bank_full[0] && !bf_prev[0]) begin
                bank_seq.push_back(1'b0);
                if (full_cyc_a < 0) full_cyc_a = cyc;
            end
            if (bank_full[1] && !bf_prev[1]) bank_seq.push_back(1'b1);
            if (bus.drain_valid && !dv_prev && dv_rise < 0) dv_rise = cyc;
            if (enableA && !writeEnableA1) begin
                nrdA++;
                last_rd_a = cyc;
                if (first_rd_a < 0) first_rd_a = cyc;
            end
            if (enableB && !writeEnableB1) nrdB++;
            if (bus.fill_ready && !fr_prev) fr_rise = cyc;
        end
        bf_prev = bank_full;
        dv_prev = bus.drain_valid;
        fr_prev = bus.fill_ready;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] q_at(input int i);
        return (i < out_q.size()) ? out_q[i] : 33'h1_dead_beef;
    endfunction

    function automatic int oc_at(input int i);
        return (i < out_cyc.size()) ? out_cyc[i] : -1000;
    endfunction

    function automatic int seq_at(input int i);
        return (i < bank_seq.size()) ? int'(bank_seq[i]) : 7;
    endfunction

    task automatic clear_mon();
        out_q.delete();
        out_cyc.delete();
        bank_seq.delete();
        nrdA = 0;
        nrdB = 0;
        full_cyc_a = -1;
        dv_rise    = -1;
        first_rd_a = -1;
        last_rd_a  = -1;
        fr_rise    = -1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_row(input logic [31:0] d, input logic l);
        int t = 0;
        bus.fill_valid = 1'b1;
        bus.fill_data  = d;
        bus.fill_last  = l;
        @(negedge clk);
        while (!bus.fill_ready && t < LIM) begin
            @(negedge clk);
            t++;
        end
        if (t >= LIM) check("fill_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #1;
        bus.fill_valid = 1'b0;
        bus.fill_last  = 1'b0;
    endtask

    task automatic send_block(input int n, input logic [31:0] base,
                              input bit use_last);
        for (int i = 0; i < n; i++)
            send_row(base + 32'(i), use_last && (i == n - 1));
    endtask

    task automatic wait_out(input string tag, input int n);
        int t = 0;
        while (out_q.size() < n && t < LIM) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(tag, 64'(out_q.size()), 64'(n));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_fill_ready"}, 64'(bus.fill_ready), 64'(1));
        check({tag, "_drain_valid"}, 64'(bus.drain_valid), 64'(0));
        check({tag, "_drain_out"}, 64'({bus.drain_last, bus.drain_data}), 64'(0));
        check({tag, "_bank_full"}, 64'(bank_full), 64'(0));
        check({tag, "_enables"}, 64'({enableA, enableB, writeEnableA1,
              writeEnableB1, writeEnableA2, writeEnableB2}), 64'(0));
        check({tag, "_addr"}, 64'({addressportA1, addressportB1,
              addressportA2, addressportB2}), 64'(0));
        check({tag, "_wport2"}, {writeportA2, writeportB2}, 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fill_valid  = 1'b0;
        bus.fill_last   = 1'b0;
        bus.fill_data   = '0;
        bus.drain_ready = 1'b0;
        clear_mon();
        do_reset();
        check_reset_vals("rst");

        // 8-row block into A, consumer always ready
        clear_mon();
        bus.drain_ready = 1'b1;
        send_block(8, 32'h0, 1'b1);
        wait_out("t1_count", 8);
        for (int i = 0; i < 8; i++)
            check("t1_row", 64'(q_at(i)), 64'({i == 7, 32'(i)}));
        check("t1_latency", 64'(dv_rise - full_cyc_a), 64'(3));
        check("t1_first_read", 64'(first_rd_a - full_cyc_a), 64'(0));
        check("t1_reads", 64'(nrdA), 64'(8));
        step(4);

        // single-row block lands in B
        clear_mon();
        send_row(32'h55, 1'b1);
        wait_out("t2_count", 1);
        check("t2_row", 64'(q_at(0)), 64'({1'b1, 32'h55}));
        check("t2_bank", 64'(seq_at(0)), 64'(1));
        step(6);
        check("t2_no_dup", 64'(out_q.size()), 64'(1));

        // three back-to-back 16-row blocks without fill_last
        do_reset();
        clear_mon();
        bus.drain_ready = 1'b1;
        for (int b = 0; b < 3; b++) send_block(16, 32'(b * 16), 1'b0);
        wait_out("t3_count", 48);
        for (int i = 0; i < 48; i++)
            check("t3_row", 64'(q_at(i)), 64'({(i % 16) == 15, 32'(i)}));
        check("t3_bank_order",
              64'(seq_at(0) * 100 + seq_at(1) * 10 + seq_at(2)), 64'(10));
        for (int b = 0; b < 3; b++)
            check("t3_block_span", 64'(oc_at(b * 16 + 15) - oc_at(b * 16)), 64'(15));

        // stalled consumer: both banks fill, skid holds 4 rows
        do_reset();
        clear_mon();
        bus.drain_ready = 1'b0;
        send_block(8, 32'h100, 1'b1);
        send_block(8, 32'h200, 1'b1);
        step(6);
        check("t4_bank_full", 64'(bank_full), 64'(3));
        check("t4_fill_ready", 64'(bus.fill_ready), 64'(0));
        check("t4_reads_a", 64'(nrdA), 64'(4));
        check("t4_reads_b", 64'(nrdB), 64'(0));
        check("t4_valid", 64'(bus.drain_valid), 64'(1));
        check("t4_head", 64'({bus.drain_last, bus.drain_data}), 64'({1'b0, 32'h100}));
        step(3);
        check("t4_hold", 64'({bus.drain_last, bus.drain_data}), 64'({1'b0, 32'h100}));
        check("t4_reads_hold", 64'(nrdA), 64'(4));
        fr_rise = -1;
        bus.drain_ready = 1'b1;
        wait_out("t4_count", 16);
        for (int i = 0; i < 16; i++)
            check("t4_row", 64'(q_at(i)), 64'({(i == 7) || (i == 15),
                  (i < 8) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 8)}));
        check("t4_reads_a_all", 64'(nrdA), 64'(8));
        check("t4_ready_return", 64'(fr_rise - last_rd_a), 64'(2));

        // reset while B fills and A drains, then a clean 4-row block
        do_reset();
        clear_mon();
        bus.drain_ready = 1'b0;
        send_block(8, 32'h100, 1'b1);
        send_block(3, 32'h400, 1'b0);
        step(2);
        do_reset();
        check_reset_vals("mid_rst");
        clear_mon();
        bus.drain_ready = 1'b1;
        send_block(4, 32'h300, 1'b1);
        wait_out("t5_count", 4);
        for (int i = 0; i < 4; i++)
            check("t5_row", 64'(q_at(i)), 64'({i == 3, 32'h300 + 32'(i)}));
        check("t5_bank", 64'(seq_at(0)), 64'(0));
        step(6);
        check("t5_no_extra", 64'(out_q.size()), 64'(4));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
